call_controller: RTL and testbench
==================================

CALL_CONTROLLER -- requirements
Module: call_controller

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 27000000, ring/answer timeout in clk cycles (1 s at 27 MHz).
REQ-002 Parameter: MY_NUM, 8'd0, this station's phone number.
REQ-003 Port: clk  in  1  system clock; all logic is on the rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: command  in  3  UI request (0 NOP, 1 DIAL, 2 ACCEPT, 3 REJECT, 4 HANGUP), one-cycle pulse per request.
REQ-006 Port: phn_num  in  8  number to dial, sampled when command==DIAL.
REQ-007 Port: inc_command  out  3  status to UI (0 NONE, 1 CONNECTED, 2 REMOTE_BUSY, 3 NO_ANSWER, 5 INCOMING, 6 CALL_ENDED).
REQ-008 Port: caller_num  out  8  peer number for the current or pending call.
REQ-009 Port: tx_valid  out  1  packet offered to the transport layer.
REQ-010 Port: tx_ready  in  1  transport accepts the packet when tx_valid&&tx_ready.
REQ-011 Port: tx_type  out  3  packet type (1 REQ, 2 ACK, 3 BUSY, 4 END, 5 REJECT).
REQ-012 Port: tx_addr  out  8  destination number.
REQ-013 Port: rx_valid  in  1  one-cycle strobe for a received packet.
REQ-014 Port: rx_type  in  3  received packet type, same encoding as tx_type.
REQ-015 Port: rx_addr  in  8  source number of the received packet.
REQ-016 Port: call_active  out  1  high only in CONNECTED; gates the audio path.

Function
REQ-017 States: IDLE, CALL_OUT, RING_IN, CONNECTED.
REQ-018 IDLE + DIAL: latch phn_num into caller_num, queue REQ to phn_num, go to CALL_OUT, start timer.
REQ-019 IDLE + rx REQ: latch rx_addr, set inc_command=5, go to RING_IN, start timer.
REQ-020 CALL_OUT + rx ACK from caller_num: set inc_command=1 and go to CONNECTED.
REQ-021 CALL_OUT + rx BUSY or REJECT from caller_num: set inc_command=2 and go to IDLE.
REQ-022 RING_IN + ACCEPT: queue ACK, set inc_command=1, go to CONNECTED.
REQ-023 RING_IN + REJECT: queue REJECT, set inc_command=6, go to IDLE.
REQ-024 CONNECTED, CALL_OUT or RING_IN + HANGUP: queue END, set inc_command=6, go to IDLE.
REQ-025 rx END from caller_num in a non-IDLE state: set inc_command=6 and go to IDLE.
REQ-026 Timer expiry in CALL_OUT or RING_IN: queue END, set inc_command=3, go to IDLE.
REQ-027 Timer is loaded with TIMEOUT_CYCLES-1 on state entry; expiry occurs on the cycle it reads 0.
REQ-028 Timer holds 0 in IDLE and CONNECTED.
REQ-029 inc_command holds its last code until the next event; an event updates it on the clock edge after the causing input.
REQ-030 rx REQ in any non-IDLE state: queue BUSY to rx_addr; state and caller_num are unchanged.
REQ-031 Packets from addresses other than caller_num are ignored, except REQ.
REQ-032 TX handshake: tx_valid, tx_type and tx_addr stay stable until tx_ready is sampled high.
REQ-033 TX handshake: tx_valid deasserts the cycle after acceptance.
REQ-034 A one-entry TX holding slot holds a queued packet while tx_valid is pending.
REQ-035 A new packet queued while the slot is full is dropped; state transitions still occur.
REQ-036 Priority when rx_valid and a UI command arrive in the same cycle: rx END, then UI command, then other rx.
REQ-037 Timer expiry coincident with ACK/ACCEPT: the connect wins.
REQ-038 Commands that are illegal for the current state are ignored, including DIAL outside IDLE and ACCEPT outside RING_IN.

Reset
REQ-039 Assertion of reset (low) asynchronously forces: state IDLE, inc_command=0, caller_num=0, tx_valid=0, tx_type=0, tx_addr=0, timer=0, call_active=0.
REQ-040 A reset asserted mid-call drops any pending packet; no END packet is sent.
REQ-041 Deassertion is synchronous to clk.

Structure
REQ-042 Shared package call_ctrl_pkg SHALL hold the UI command codes, inc_command codes, packet type codes and the state encoding.
REQ-043 Sub-module call_timer SHALL implement the down-counter with load, clear and expired signals.

Verification
REQ-044 Scenario (TIMEOUT_CYCLES=16, tx_ready tied to 1):
- Stimulus: DIAL with phn_num=8'h04, then rx ACK from 8'h04.
- Response: tx REQ to 8'h04 and inc_command=1.
- Then HANGUP: tx END to 8'h04, inc_command=6, IDLE.
REQ-045 Scenario: rx REQ from 8'h09, then ACCEPT.
- Response: inc_command=5, then tx ACK to 8'h09, inc_command=1, call_active=1.
REQ-046 Scenario: DIAL 8'h04 with no reply.
- Response: after 16 cycles, tx END to 8'h04, inc_command=3, IDLE.
REQ-047 Scenario: in CONNECTED with 8'h09, rx REQ from 8'h07.
- Response: tx BUSY to 8'h07; state stays CONNECTED and caller_num stays 8'h09.
REQ-048 Scenario: tx_ready held low for 5 cycles during an ACK.
- Response: tx_valid and fields stay stable; exactly one transfer occurs.
REQ-049 Scenario: reset low mid-call in CONNECTED.
- Response: all outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/call_ctrl_pkg.sv
// Shared codes for the call controller: UI commands, UI status, packet types and FSM states.
package call_ctrl_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned NUM_W  = 8;
  localparam int unsigned ST_W   = 2;

  localparam logic [CODE_W-1:0] CMD_NOP    = 3'd0;
  localparam logic [CODE_W-1:0] CMD_DIAL   = 3'd1;
  localparam logic [CODE_W-1:0] CMD_ACCEPT = 3'd2;
  localparam logic [CODE_W-1:0] CMD_REJECT = 3'd3;
  localparam logic [CODE_W-1:0] CMD_HANGUP = 3'd4;

  localparam logic [CODE_W-1:0] INC_NONE        = 3'd0;
  localparam logic [CODE_W-1:0] INC_CONNECTED   = 3'd1;
  localparam logic [CODE_W-1:0] INC_REMOTE_BUSY = 3'd2;
  localparam logic [CODE_W-1:0] INC_NO_ANSWER   = 3'd3;
  localparam logic [CODE_W-1:0] INC_INCOMING    = 3'd5;
  localparam logic [CODE_W-1:0] INC_CALL_ENDED  = 3'd6;

  localparam logic [CODE_W-1:0] PKT_NONE   = 3'd0;
  localparam logic [CODE_W-1:0] PKT_REQ    = 3'd1;
  localparam logic [CODE_W-1:0] PKT_ACK    = 3'd2;
  localparam logic [CODE_W-1:0] PKT_BUSY   = 3'd3;
  localparam logic [CODE_W-1:0] PKT_END    = 3'd4;
  localparam logic [CODE_W-1:0] PKT_REJECT = 3'd5;

  localparam logic [ST_W-1:0] ST_IDLE      = 2'd0;
  localparam logic [ST_W-1:0] ST_CALL_OUT  = 2'd1;
  localparam logic [ST_W-1:0] ST_RING_IN   = 2'd2;
  localparam logic [ST_W-1:0] ST_CONNECTED = 2'd3;

  typedef struct packed {
    logic [CODE_W-1:0] ptype;
    logic [NUM_W-1:0]  addr;
  } tx_pkt_t;

  function automatic tx_pkt_t make_pkt(input logic [CODE_W-1:0] ptype, input logic [NUM_W-1:0] addr);
    tx_pkt_t p;
    p.ptype = ptype;
    p.addr  = addr;
    return p;
  endfunction

endpackage

// File: rtl/call_timer.sv
// Ring/answer down-counter: load on entry to a timed state, clear otherwise, expired when it reads 0.
module call_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic expired_c
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              count <= '0;
    else if (load)           count <= TW'(TIMEOUT_CYCLES - 1);
    else if (clear)          count <= '0;
    else if (count != '0)    count <= count - TW'(1);
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/call_controller.sv
// Call signalling FSM: UI commands and received packets drive call state, status codes and TX packets.
module call_controller
  import call_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 27000000,
  parameter logic [7:0]  MY_NUM         = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] command,
  input  logic [7:0] phn_num,
  output logic [2:0] inc_command,
  output logic [7:0] caller_num,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [2:0] tx_type,
  output logic [7:0] tx_addr,
  input  logic       rx_valid,
  input  logic [2:0] rx_type,
  input  logic [7:0] rx_addr,
  output logic       call_active
);

  logic [ST_W-1:0]   state, state_n;
  logic [CODE_W-1:0] inc_n;
  logic [NUM_W-1:0]  caller_n;
  logic              q_en;
  tx_pkt_t           q_pkt;
  tx_pkt_t           slot;
  logic              slot_valid;
  logic              expired_c, timer_load_c, timer_clear_c;
  logic              rx_ok_c, rx_peer_c, rx_req_c, tx_free_c;

  // Our own number echoed back by the transport is never a real peer.
  assign rx_ok_c   = rx_valid && (rx_addr != MY_NUM);
  assign rx_peer_c = rx_ok_c && (rx_addr == caller_num);
  assign rx_req_c  = rx_ok_c && (rx_type == PKT_REQ);

  call_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load_c),
    .clear     (timer_clear_c),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Priority: peer END, then UI command, then other rx; expiry only when nothing else moves the FSM.
  always_comb begin
    state_n  = state;
    inc_n    = inc_command;
    caller_n = caller_num;
    q_en     = 1'b0;
    q_pkt    = '0;
    if ((state != ST_IDLE) && rx_peer_c && (rx_type == PKT_END)) begin
      state_n = ST_IDLE;
      inc_n   = INC_CALL_ENDED;
    end else begin
      case (state)
        ST_IDLE: begin
          if (command == CMD_DIAL) begin
            state_n  = ST_CALL_OUT;
            caller_n = phn_num;
            q_en     = 1'b1;
            q_pkt    = make_pkt(PKT_REQ, phn_num);
          end else if (rx_req_c) begin
            state_n  = ST_RING_IN;
            caller_n = rx_addr;
            inc_n    = INC_INCOMING;
          end
        end
        ST_CALL_OUT: begin
          if (command == CMD_HANGUP) begin
            state_n = ST_IDLE;
            inc_n   = INC_CALL_ENDED;
            q_en    = 1'b1;
            q_pkt   = make_pkt(PKT_END, caller_num);
          end else if (rx_peer_c && (rx_type == PKT_ACK)) begin
            state_n = ST_CONNECTED;
            inc_n   = INC_CONNECTED;
          end else if (rx_peer_c && ((rx_type == PKT_BUSY) || (rx_type == PKT_REJECT))) begin
            state_n = ST_IDLE;
            inc_n   = INC_REMOTE_BUSY;
          end else if (expired_c) begin
            state_n = ST_IDLE;
            inc_n   = INC_NO_ANSWER;
            q_en    = 1'b1;
            q_pkt   = make_pkt(PKT_END, caller_num);
          end else if (rx_req_c) begin
            q_en  = 1'b1;
            q_pkt = make_pkt(PKT_BUSY, rx_addr);
          end
        end
        ST_RING_IN: begin
          if (command == CMD_HANGUP) begin
            state_n = ST_IDLE;
            inc_n   = INC_CALL_ENDED;
            q_en    = 1'b1;
            q_pkt   = make_pkt(PKT_END, caller_num);
          end else if (command == CMD_ACCEPT) begin
            state_n = ST_CONNECTED;
            inc_n   = INC_CONNECTED;
            q_en    = 1'b1;
            q_pkt   = make_pkt(PKT_ACK, caller_num);
          end else if (command == CMD_REJECT) begin
            state_n = ST_IDLE;
            inc_n   = INC_CALL_ENDED;
            q_en    = 1'b1;
            q_pkt   = make_pkt(PKT_REJECT, caller_num);
          end else if (expired_c) begin
            state_n = ST_IDLE;
            inc_n   = INC_NO_ANSWER;
            q_en    = 1'b1;
            q_pkt   = make_pkt(PKT_END, caller_num);
          end else if (rx_req_c) begin
            q_en  = 1'b1;
            q_pkt = make_pkt(PKT_BUSY, rx_addr);
          end
        end
        default: begin
          if (command == CMD_HANGUP) begin
            state_n = ST_IDLE;
            inc_n   = INC_CALL_ENDED;
            q_en    = 1'b1;
            q_pkt   = make_pkt(PKT_END, caller_num);
          end else if (rx_req_c) begin
            q_en  = 1'b1;
            q_pkt = make_pkt(PKT_BUSY, rx_addr);
          end
        end
      endcase
    end
  end

  assign timer_clear_c = (state_n == ST_IDLE) || (state_n == ST_CONNECTED);
  assign timer_load_c  = !timer_clear_c && (state_n != state);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_command <= INC_NONE;
      caller_num  <= '0;
      call_active <= 1'b0;
    end else begin
      inc_command <= inc_n;
      caller_num  <= caller_n;
      call_active <= (state_n == ST_CONNECTED);
    end
  end

  // Output register plus one holding slot; a packet arriving with both full is dropped.
  assign tx_free_c = !tx_valid || tx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid   <= 1'b0;
      tx_type    <= '0;
      tx_addr    <= '0;
      slot       <= '0;
      slot_valid <= 1'b0;
    end else if (tx_free_c) begin
      if (slot_valid) begin
        tx_valid   <= 1'b1;
        tx_type    <= slot.ptype;
        tx_addr    <= slot.addr;
        slot       <= q_pkt;
        slot_valid <= q_en;
      end else if (q_en) begin
        tx_valid <= 1'b1;
        tx_type  <= q_pkt.ptype;
        tx_addr  <= q_pkt.addr;
      end else begin
        tx_valid <= 1'b0;
      end
    end else if (q_en && !slot_valid) begin
      slot       <= q_pkt;
      slot_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_call_controller.sv
// Directed bench for call_controller with a 16-cycle timeout.
module tb_call_controller;
  import call_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] command = 3'd0;
  logic [7:0] phn_num = 8'd0;
  logic [2:0] inc_command;
  logic [7:0] caller_num;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [2:0] tx_type;
  logic [7:0] tx_addr;
  logic       rx_valid = 1'b0;
  logic [2:0] rx_type = 3'd0;
  logic [7:0] rx_addr = 8'd0;
  logic       call_active;

  int pass_n = 0;
  int chk_n  = 0;
  logic [10:0] acc_q[$];

  always #5 clk = ~clk;

  call_controller #(.TIMEOUT_CYCLES(16), .MY_NUM(8'd0)) dut (
    .clk(clk), .reset(reset), .command(command), .phn_num(phn_num),
    .inc_command(inc_command), .caller_num(caller_num),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_type(tx_type), .tx_addr(tx_addr),
    .rx_valid(rx_valid), .rx_type(rx_type), .rx_addr(rx_addr), .call_active(call_active)
  );

  // Log every accepted transfer as {type, addr}.
  always @(posedge clk) if (reset && tx_valid && tx_ready) acc_q.push_back({tx_type, tx_addr});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [7:0] n);
    command = c;
    phn_num = n;
    tick();
    command = CMD_NOP;
  endtask

  task automatic rx(input logic [2:0] t, input logic [7:0] a);
    rx_valid = 1'b1;
    rx_type  = t;
    rx_addr  = a;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    chk_n++; if (inc_command !== 3'd0) $display("FAIL rst_inc got %0d want 0", inc_command); else pass_n++;
    chk_n++; if (caller_num !== 8'h00) $display("FAIL rst_caller got %h want 00", caller_num); else pass_n++;
    chk_n++; if ({tx_valid, tx_type, tx_addr, call_active} !== 13'd0) $display("FAIL rst_tx got %b want 0", {tx_valid, tx_type, tx_addr, call_active}); else pass_n++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_dial_connect_hangup();
    acc_q.delete();
    cmd(CMD_DIAL, 8'h04);
    chk_n++; if ({tx_valid, tx_type, tx_addr} !== {1'b1, PKT_REQ, 8'h04}) $display("FAIL dial_tx got %b want %b", {tx_valid, tx_type, tx_addr}, {1'b1, PKT_REQ, 8'h04}); else pass_n++;
    chk_n++; if (caller_num !== 8'h04) $display("FAIL dial_caller got %h want 04", caller_num); else pass_n++;
    chk_n++; if (inc_command !== INC_NONE) $display("FAIL dial_inc got %0d want 0", inc_command); else pass_n++;
    rx(PKT_ACK, 8'h04);
    chk_n++; if (inc_command !== INC_CONNECTED) $display("FAIL ack_inc got %0d want 1", inc_command); else pass_n++;
    chk_n++; if (call_active !== 1'b1) $display("FAIL ack_active got %b want 1", call_active); else pass_n++;
    chk_n++; if (tx_valid !== 1'b0 || acc_q.size() != 1) $display("FAIL req_xfer got valid=%b n=%0d want valid=0 n=1", tx_valid, acc_q.size()); else pass_n++;
    cmd(CMD_HANGUP, 8'h00);
    chk_n++; if ({tx_valid, tx_type, tx_addr} !== {1'b1, PKT_END, 8'h04}) $display("FAIL hangup_tx got %b want %b", {tx_valid, tx_type, tx_addr}, {1'b1, PKT_END, 8'h04}); else pass_n++;
    chk_n++; if (inc_command !== INC_CALL_ENDED || call_active !== 1'b0) $display("FAIL hangup_inc got %0d/%b want 6/0", inc_command, call_active); else pass_n++;
    tick();
  endtask

  task automatic test_incoming_accept();
    rx(PKT_REQ, 8'h09);
    chk_n++; if (inc_command !== INC_INCOMING || caller_num !== 8'h09) $display("FAIL ring_inc got %0d/%h want 5/09", inc_command, caller_num); else pass_n++;
    chk_n++; if (tx_valid !== 1'b0 || call_active !== 1'b0) $display("FAIL ring_tx got %b/%b want 0/0", tx_valid, call_active); else pass_n++;
    cmd(CMD_ACCEPT, 8'h00);
    chk_n++; if ({tx_valid, tx_type, tx_addr} !== {1'b1, PKT_ACK, 8'h09}) $display("FAIL accept_tx got %b want %b", {tx_valid, tx_type, tx_addr}, {1'b1, PKT_ACK, 8'h09}); else pass_n++;
    chk_n++; if (inc_command !== INC_CONNECTED || call_active !== 1'b1) $display("FAIL accept_inc got %0d/%b want 1/1", inc_command, call_active); else pass_n++;
    tick();
  endtask

  task automatic test_busy_while_connected();
    rx(PKT_REQ, 8'h07);
    chk_n++; if ({tx_valid, tx_type, tx_addr} !== {1'b1, PKT_BUSY, 8'h07}) $display("FAIL busy_tx got %b want %b", {tx_valid, tx_type, tx_addr}, {1'b1, PKT_BUSY, 8'h07}); else pass_n++;
    chk_n++; if (caller_num !== 8'h09 || call_active !== 1'b1) $display("FAIL busy_keep got %h/%b want 09/1", caller_num, call_active); else pass_n++;
    cmd(CMD_DIAL, 8'h55);
    chk_n++; if (tx_valid !== 1'b0 || caller_num !== 8'h09 || inc_command !== INC_CONNECTED) $display("FAIL dial_ignored got %b/%h/%0d want 0/09/1", tx_valid, caller_num, inc_command); else pass_n++;
    rx(PKT_END, 8'h07);
    chk_n++; if (call_active !== 1'b1 || inc_command !== INC_CONNECTED) $display("FAIL foreign_end got %b/%0d want 1/1", call_active, inc_command); else pass_n++;
    rx(PKT_END, 8'h09);
    chk_n++; if (call_active !== 1'b0 || inc_command !== INC_CALL_ENDED || tx_valid !== 1'b0) $display("FAIL peer_end got %b/%0d/%b want 0/6/0", call_active, inc_command, tx_valid); else pass_n++;
  endtask

  task automatic test_timeout_and_reject();
    cmd(CMD_DIAL, 8'h04);
    tick();
    repeat (14) tick();
    chk_n++; if (inc_command !== INC_CALL_ENDED || tx_valid !== 1'b0) $display("FAIL pre_timeout got %0d/%b want 6/0", inc_command, tx_valid); else pass_n++;
    tick();
    chk_n++; if ({tx_valid, tx_type, tx_addr} !== {1'b1, PKT_END, 8'h04}) $display("FAIL timeout_tx got %b want %b", {tx_valid, tx_type, tx_addr}, {1'b1, PKT_END, 8'h04}); else pass_n++;
    chk_n++; if (inc_command !== INC_NO_ANSWER) $display("FAIL timeout_inc got %0d want 3", inc_command); else pass_n++;
    tick();
    rx(PKT_REQ, 8'h22);
    chk_n++; if (inc_command !== INC_INCOMING || caller_num !== 8'h22) $display("FAIL idle_after_timeout got %0d/%h want 5/22", inc_command, caller_num); else pass_n++;
    cmd(CMD_REJECT, 8'h00);
    chk_n++; if ({tx_valid, tx_type, tx_addr} !== {1'b1, PKT_REJECT, 8'h22}) $display("FAIL reject_tx got %b want %b", {tx_valid, tx_type, tx_addr}, {1'b1, PKT_REJECT, 8'h22}); else pass_n++;
    chk_n++; if (inc_command !== INC_CALL_ENDED) $display("FAIL reject_inc got %0d want 6", inc_command); else pass_n++;
    tick();
  endtask

  task automatic test_accept_at_expiry();
    rx(PKT_REQ, 8'h11);
    repeat (15) tick();
    cmd(CMD_ACCEPT, 8'h00);
    chk_n++; if (inc_command !== INC_CONNECTED || call_active !== 1'b1) $display("FAIL expiry_accept got %0d/%b want 1/1", inc_command, call_active); else pass_n++;
    chk_n++; if ({tx_valid, tx_type, tx_addr} !== {1'b1, PKT_ACK, 8'h11}) $display("FAIL expiry_ack got %b want %b", {tx_valid, tx_type, tx_addr}, {1'b1, PKT_ACK, 8'h11}); else pass_n++;
    tick();
    cmd(CMD_HANGUP, 8'h00);
    tick();
  endtask

  task automatic test_backpressure();
    tx_ready = 1'b0;
    rx(PKT_REQ, 8'h09);
    cmd(CMD_ACCEPT, 8'h00);
    acc_q.delete();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin rx_valid = 1'b1; rx_type = PKT_REQ; rx_addr = 8'h07; end
      if (i == 1) begin rx_valid = 1'b1; rx_type = PKT_REQ; rx_addr = 8'h08; end
      tick();
      rx_valid = 1'b0;
      chk_n++; if ({tx_valid, tx_type, tx_addr} !== {1'b1, PKT_ACK, 8'h09} || acc_q.size() != 0) $display("FAIL stall_%0d got %b n=%0d want %b n=0", i, {tx_valid, tx_type, tx_addr}, acc_q.size(), {1'b1, PKT_ACK, 8'h09}); else pass_n++;
    end
    tx_ready = 1'b1;
    tick();
    chk_n++; if ({tx_valid, tx_type, tx_addr} !== {1'b1, PKT_BUSY, 8'h07}) $display("FAIL slot_tx got %b want %b", {tx_valid, tx_type, tx_addr}, {1'b1, PKT_BUSY, 8'h07}); else pass_n++;
    tick();
    chk_n++; if (tx_valid !== 1'b0 || acc_q.size() != 2) $display("FAIL xfer_count got valid=%b n=%0d want valid=0 n=2", tx_valid, acc_q.size()); else pass_n++;
    chk_n++; if (acc_q.size() == 2 && (acc_q[0] !== {PKT_ACK, 8'h09} || acc_q[1] !== {PKT_BUSY, 8'h07})) $display("FAIL xfer_order got %h,%h want %h,%h", acc_q[0], acc_q[1], {PKT_ACK, 8'h09}, {PKT_BUSY, 8'h07}); else pass_n++;
    chk_n++; if (call_active !== 1'b1 || caller_num !== 8'h09) $display("FAIL bp_state got %b/%h want 1/09", call_active, caller_num); else pass_n++;
  endtask

  task automatic test_reset_mid_call();
    tx_ready = 1'b0;
    rx(PKT_REQ, 8'h07);
    chk_n++; if (tx_valid !== 1'b1 || call_active !== 1'b1) $display("FAIL pre_reset got %b/%b want 1/1", tx_valid, call_active); else pass_n++;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk_n++; if ({inc_command, caller_num, tx_valid, tx_type, tx_addr, call_active} !== 24'd0) $display("FAIL async_reset got %h want 0", {inc_command, caller_num, tx_valid, tx_type, tx_addr, call_active}); else pass_n++;
    #2 reset = 1'b1;
    tx_ready = 1'b1;
    acc_q.delete();
    repeat (3) tick();
    chk_n++; if (acc_q.size() != 0 || tx_valid !== 1'b0 || inc_command !== INC_NONE) $display("FAIL post_reset got n=%0d/%b/%0d want 0/0/0", acc_q.size(), tx_valid, inc_command); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_dial_connect_hangup();
    test_incoming_accept();
    test_busy_while_connected();
    test_timeout_and_reject();
    test_accept_at_expiry();
    test_backpressure();
    test_reset_mid_call();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
